// File: rtl/zprize_msm_pkg.sv
// Shared definitions for the MSM multiplier back end.
// Holds the multiplier metadata layout, default product/metadata widths and
// the helper that sizes occupancy/credit counters.
package zprize_msm_pkg;

    // Metadata layout produced alongside each multiplier product
    localparam int unsigned MUL_META_VLD_BIT = 0;
    localparam int unsigned MUL_META_TAG_LSB = 1;

    // Default widths: product is 2x the multiplier operand width
    localparam int unsigned MUL_W_DFLT = 768;
    localparam int unsigned MUL_M_DFLT = 32;

    // Width needed to count 0..depth inclusive
    function automatic int unsigned mul_drain_cw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/zprize_drain_fifo_mem.sv
// Storage array for the multiplier drain FIFO.
// One synchronous write port, one asynchronous read port; contents are not
// reset so the array can be swapped for a vendor RAM macro.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module zprize_drain_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 799,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Show-ahead read port
    assign rdata = mem[raddr];

endmodule

// File: rtl/zprize_mul_drain.sv
// Collector for the fixed-latency Karatsuba product pipeline.
// Every beat flagged valid in the metadata is captured into a show-ahead FIFO
// and offered downstream over valid/ready. Each pop returns a one-cycle
// credit pulse so the issuer never has more products in flight than free
// slots.
// Optional: define ZPRIZE_MUL_DRAIN_OVF_CHECK_EN to enable the sticky
// overflow flag and simulation checks; otherwise ovf_o is tied low.
// Ports:
//   clk        - clock
//   rst        - asynchronous active-low reset
//   in_data    - product from multiplier
//   in_meta    - metadata; bit 0 marks a real beat, upper bits are the tag
//   out_data   - head-of-FIFO product
//   out_tag    - head-of-FIFO tag
//   out_valid  - head entry present
//   out_ready  - consumer accepts head
//   credit_o   - one-cycle pulse per freed slot
//   count_o    - current occupancy
//   ovf_o      - sticky overflow error
module zprize_mul_drain
    import zprize_msm_pkg::*;
#(
    parameter int unsigned W     = MUL_W_DFLT,
    parameter int unsigned M     = MUL_M_DFLT,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = mul_drain_cw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic [M-1:0]  in_meta,
    output logic [W-1:0]  out_data,
    output logic [M-2:0]  out_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          credit_o,
    output logic [CW-1:0] count_o,
    output logic          ovf_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = W + M - 1;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          credit_q, credit_d;

    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          ovf_evt;
    logic [DW-1:0] rdata;

    // Handshake decode; full/empty come from the occupancy count
    always_comb begin
        push_req = in_meta[MUL_META_VLD_BIT];
        pop      = (count_q != '0) && out_ready;
        full     = (count_q == CW'(DEPTH));
        // When full, a push only lands if the head is vacating its slot
        push     = push_req && (!full || pop);
        ovf_evt  = push_req && full && !pop;
    end

    // Next-state for pointers, count and credit
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        credit_d = pop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            credit_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
        end
    end

    zprize_drain_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({in_data, in_meta[M-1:MUL_META_TAG_LSB]}),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign out_data  = rdata[DW-1:M-1];
    assign out_tag   = rdata[M-2:0];
    assign out_valid = (count_q != '0);
    assign credit_o  = credit_q;
    assign count_o   = count_q;

`ifdef ZPRIZE_MUL_DRAIN_OVF_CHECK_EN
    logic ovf_q;

    // Sticky until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (ovf_evt) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;

    // synopsys-neutral simulation checks
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !ovf_evt)
        else $error("zprize_mul_drain: push dropped on full FIFO");

    a_head_stable: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready) |=> $stable(out_data))
        else $error("zprize_mul_drain: head data changed while stalled");
`else
    assign ovf_o = 1'b0;

    logic unused_ovf;
    assign unused_ovf = ovf_evt;
`endif

endmodule

// File: tb/tb_zprize_mul_drain.sv
// Directed bench for zprize_mul_drain: single beat, idle beats, fill/stall,
// full with simultaneous push/pop, overflow drop and asynchronous reset.
module tb_zprize_mul_drain;

    localparam int unsigned W     = 768;
    localparam int unsigned M     = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 5;

    logic          clk;
    logic          rst;
    logic [W-1:0]  in_data;
    logic [M-1:0]  in_meta;
    logic [W-1:0]  out_data;
    logic [M-2:0]  out_tag;
    logic          out_valid;
    logic          out_ready;
    logic          credit_o;
    logic [CW-1:0] count_o;
    logic          ovf_o;

    int n_vec;
    int n_bad;
    int n_cred;

`ifdef ZPRIZE_MUL_DRAIN_OVF_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    zprize_mul_drain #(
        .W     (W),
        .M     (M),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_meta   (in_meta),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .credit_o  (credit_o),
        .count_o   (count_o),
        .ovf_o     (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Recognisable product for a given tag
    function automatic logic [W-1:0] pdata(input int tag);
        logic [W-1:0] d;
        d          = '0;
        d[31:0]    = 32'hC0DE_0000 ^ 32'(tag);
        d[767:736] = 32'(tag);
        return d;
    endfunction

    // Advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input int tag);
        in_meta = {31'(tag), 1'b1};
        in_data = pdata(tag);
    endtask

    task automatic idle_in();
        in_meta = '0;
        in_data = '0;
    endtask

    // Push tags base..base+n-1 with the consumer stalled
    task automatic fill(input int base, input int n);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            set_push(base + i);
            step();
        end
        idle_in();
    endtask

    task automatic drain_expect(input string tag, input int first, input int n);
        out_ready = 1'b1;
        n_cred    = 0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_tag"}, W'(out_tag), W'(first + i));
            chk({tag, "_data"}, out_data, pdata(first + i));
            step();
            n_cred += int'(credit_o);
        end
        chk({tag, "_credits"}, W'(n_cred), W'(n));
        chk({tag, "_cnt_end"}, W'(count_o), W'(0));
        chk({tag, "_vld_end"}, W'(out_valid), W'(0));
        out_ready = 1'b0;
        step();
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b0;
        out_ready = 1'b0;
        idle_in();
        #12;
        chk("rst_cnt", W'(count_o), W'(0));
        chk("rst_vld", W'(out_valid), W'(0));
        chk("rst_cred", W'(credit_o), W'(0));
        chk("rst_ovf", W'(ovf_o), W'(0));
        @(negedge clk);
        rst = 1'b1;
        step();

        // Single beat
        in_meta   = 32'h0000_0AB1;
        in_data   = 768'h1234;
        out_ready = 1'b1;
        chk("single_vld_pre", W'(out_valid), W'(0));
        step();
        idle_in();
        chk("single_vld", W'(out_valid), W'(1));
        chk("single_tag", W'(out_tag), W'(31'h0558));
        chk("single_data", out_data, 768'h1234);
        chk("single_cnt1", W'(count_o), W'(1));
        chk("single_cred0", W'(credit_o), W'(0));
        step();
        chk("single_cred1", W'(credit_o), W'(1));
        chk("single_cnt0", W'(count_o), W'(0));
        chk("single_vld0", W'(out_valid), W'(0));
        step();
        chk("single_cred_off", W'(credit_o), W'(0));

        // Idle beats
        for (int i = 0; i < 10; i++) begin
            in_meta   = $urandom() & 32'hFFFF_FFFE;
            in_data   = {24{$urandom()}};
            out_ready = 1'($urandom());
            step();
            chk("idle_cnt", W'(count_o), W'(0));
            chk("idle_vld", W'(out_valid), W'(0));
            chk("idle_cred", W'(credit_o), W'(0));
        end
        idle_in();

        // Fill and stall, then release
        fill(0, 16);
        chk("fill_cnt", W'(count_o), W'(16));
        chk("fill_ovf", W'(ovf_o), W'(0));
        step();
        chk("stall_cnt", W'(count_o), W'(16));
        chk("stall_cred", W'(credit_o), W'(0));
        drain_expect("fill", 0, 16);

        // Full with simultaneous push and pop
        fill(0, 16);
        set_push(16);
        out_ready = 1'b1;
        chk("fpp_head", W'(out_tag), W'(0));
        step();
        idle_in();
        out_ready = 1'b0;
        chk("fpp_cnt", W'(count_o), W'(16));
        chk("fpp_ovf", W'(ovf_o), W'(0));
        chk("fpp_cred", W'(credit_o), W'(1));
        drain_expect("fpp", 1, 16);

        // Overflow: push on full with no pop is dropped
        fill(0, 16);
        set_push(99);
        out_ready = 1'b0;
        step();
        idle_in();
        chk("ovf_cnt", W'(count_o), W'(16));
        chk("ovf_flag", W'(ovf_o), W'(OVF_EXP));
        drain_expect("ovf", 0, 16);
        chk("ovf_sticky", W'(ovf_o), W'(OVF_EXP));

        // Async reset mid-drain with 7 entries held
        fill(0, 10);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("ar_cnt7", W'(count_o), W'(7));
        chk("ar_cred_pre", W'(credit_o), W'(1));
        #1;
        rst = 1'b0;
        #1;
        chk("ar_vld", W'(out_valid), W'(0));
        chk("ar_cnt", W'(count_o), W'(0));
        chk("ar_cred", W'(credit_o), W'(0));
        chk("ar_ovf", W'(ovf_o), W'(0));
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("ar_post_vld", W'(out_valid), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/zprize_mul_drain.md
Name: zprize_mul_drain

Overview:
Downstream collector for the fixed-latency Karatsuba product pipeline. That pipeline has no backpressure, so this block captures every valid {product, metadata} beat into a show-ahead FIFO. It presents the beats to the next stage (modular reduction) over valid/ready. It returns one-cycle credit pulses so the issue side never has more products in flight than free FIFO slots.

Parameters:
W, 768, product width (2x operand width of the multiplier)
M, 32, metadata width; bit 0 = beat-valid flag, bits M-1:1 = tag
DEPTH, 16, FIFO entries; power of two, >= 4
CW, $clog2(DEPTH+1), occupancy/credit counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_data  in  W  product from multiplier out0
in_meta  in  M  metadata from multiplier m_o; in_meta[0]=1 marks a real beat
out_data  out  W  head-of-FIFO product
out_tag  out  M-1  head-of-FIFO tag (in_meta[M-1:1])
out_valid  out  1  head entry present
out_ready  in  1  consumer accepts head
credit_o  out  1  one-cycle pulse per freed slot
count_o  out  CW  current occupancy
ovf_o  out  1  sticky overflow error

Behaviour:
- Reset (rst low, async): rd_ptr=wr_ptr=0, count_o=0, out_valid=0, credit_o=0, ovf_o=0. FIFO storage is not reset. out_data and out_tag are don't-care while out_valid=0.
- Push: when in_meta[0]=1 at a rising edge, write {in_data, in_meta[M-1:1]} at wr_ptr, then increment wr_ptr (mod DEPTH). Beats with in_meta[0]=0 are ignored entirely.
- Pop: when out_valid && out_ready at a rising edge, increment rd_ptr (mod DEPTH).
- Show-ahead read: out_data and out_tag are driven combinationally from mem[rd_ptr]. out_valid = (count_o != 0).
- Latency: a beat pushed at edge k is visible with out_valid=1 after edge k (zero bubble). Back-to-back pushes and pops sustain 1 beat/clk.
- count_o changes by +1 on push only, -1 on pop only, and 0 on both or neither.
- Full plus simultaneous push and pop: legal. The write lands in the slot being vacated, the read presents old data that cycle, and count stays DEPTH.
- Full plus push without pop: overflow. The write is dropped, pointers and count are unchanged, and ovf_o sets and stays 1 until reset.
- Empty: out_ready is ignored and no pop occurs. out_valid=0 even if a push occurs the same edge, because data appears the next cycle.
- credit_o is registered: it is 1 in the cycle after each pop handshake, otherwise 0. There is exactly one pulse per pop. The upstream issuer initialises to DEPTH credits, decrements per issue, and increments per pulse.
- Pointer wrap: pointers are log2(DEPTH) bits with natural wrap. Full/empty are derived from count_o, not from pointer compare.
- Reset mid-stream: all contents are lost and no credits are returned. The issuer must be reset together with this block.

Optional Feature:
- Macro: ZPRIZE_MUL_DRAIN_OVF_CHECK_EN
- Defined: ovf_o behaves as above. A simulation-only assertion also fires on overflow and on out_ready-independent changes of out_data while out_valid && !out_ready.
- Undefined: ovf_o is tied to 0, and the overflow detect logic and assertions are removed. A full-without-pop push still drops the beat silently.

Decomposition:
- Shared package zprize_msm_pkg holds:
  - the metadata layout constants (MUL_META_VLD_BIT=0, MUL_META_TAG_LSB=1);
  - the default product width W=768 and M=32;
  - the credit-width function.
- One sub-module, zprize_drain_fifo_mem: simple dual-port storage with DEPTH x (W+M-1) bits, 1 write port, and 1 asynchronous read port. This keeps the RAM inferable/replaceable by URAM later.
- Pointer, count, credit and overflow logic stay in zprize_mul_drain.

Test Plan:
- Single beat: in_meta=32'h0000_0AB1, in_data=768'h1234 at edge 0, out_ready=1. Required: out_valid=1 with out_tag=31'h0558 and out_data=768'h1234 after edge 0; pop at edge 1; credit_o=1 during the cycle after edge 1; count_o returns to 0.
- Idle beats: 10 cycles of in_meta[0]=0 with random in_data. Required: count_o=0, out_valid=0, credit_o never 1.
- Fill and stall: 16 beats with tags 0..15 and out_ready=0. Required: count_o=16, ovf_o=0. Then release out_ready=1. Required: tags 0..15 in order, 16 credit pulses, and final count_o=0.
- Full with simultaneous push and pop: fill to 16, then push tag 16 with out_ready=1 in the same cycle. Required: head tag 0 popped, count_o stays 16, ovf_o=0, and tag 16 is later emitted after tag 15.
- Overflow: fill to 16, then push tag 99 with out_ready=0. Required: ovf_o=1 (macro defined) or 0 (undefined), count_o=16, and tag 99 never emitted.
- Async reset: assert rst low mid-drain with count_o=7. Required: out_valid, count_o, credit_o and ovf_o are all 0 immediately, without waiting for a clock edge.
